// File: rtl/tx_fifo_pkg.sv
// Shared DAT transmit-path constants: FIFO word width, default depth and flag thresholds.
// Imported by the tx_fifo storage and control logic.
package tx_fifo_pkg;

  localparam int FIFO_WIDTH     = 32;
  localparam int TX_FIFO_ADDR_W = 3;
  localparam int TX_FIFO_AE_LVL = 1;

  // almost_full sits two words below full by default
  function automatic int tx_fifo_af_lvl(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// Storage array for tx_fifo: one synchronous write port, one asynchronous read port.
// The array has no reset.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx_fifo.sv
// Show-ahead transmit FIFO feeding the DAT transmit stage.
// Pointers, count and status flags live here; storage is in fifo_mem.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_WIDTH,
  parameter int ADDR_W = TX_FIFO_ADDR_W,
  parameter int AF_LVL = tx_fifo_af_lvl(ADDR_W),
  parameter int AE_LVL = TX_FIFO_AE_LVL
) (
  input  logic              sd_clk,
  input  logic              rst_L,
  input  logic              flush,
  input  logic              wr_enb,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_enb,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);

  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            push, pop, mem_we;
  logic [DATA_W-1:0] rd_data;

  // Status decoded purely from registered state
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]) &&
                 (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign pop    = rd_enb && !empty;
  assign push   = wr_enb && (!full || pop);
  assign mem_we = push && !flush && rst_L;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      if (wr_enb && full && !pop) ovf_d = 1'b1;
      if (rd_enb && empty)        udf_d = 1'b1;
    end
  end

  always_ff @(posedge sd_clk) begin
    if (!rst_L) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (sd_clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign dout = empty ? '0 : rd_data;

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: vector table for the fill/overflow path,
// queue scoreboard for data ordering, flush, reset and random traffic.
module tb_tx_fifo;

  logic        sd_clk = 1'b0;
  logic        rst_L;
  logic        flush;
  logic        wr_enb;
  logic [31:0] din;
  logic        rd_enb;
  logic [31:0] dout;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  always #5 sd_clk = ~sd_clk;

  tx_fifo dut (
    .sd_clk       (sd_clk),
    .rst_L        (rst_L),
    .flush        (flush),
    .wr_enb       (wr_enb),
    .din          (din),
    .rd_enb       (rd_enb),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    bit          w;
    bit          r;
    bit          f;
    bit          rs;
    logic [31:0] d;
    int          e_count;
    bit          e_empty;
    bit          e_full;
    bit          e_af;
    bit          e_ae;
    bit          e_ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_state();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == 8));
    check("almost_full", 32'(almost_full), 32'(n >= 6));
    check("almost_empty", 32'(almost_empty), 32'(n <= 1));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    check("dout", dout, (n > 0) ? q[0] : 32'h0);
  endtask

  task automatic cycle(bit w, bit r, bit f, bit rs, logic [31:0] d);
    int n;
    bit pop;
    bit push;
    wr_enb = w;
    rd_enb = r;
    flush  = f;
    rst_L  = rs;
    din    = d;
    n    = q.size();
    pop  = rs && !f && r && (n > 0);
    push = rs && !f && w && ((n < 8) || pop);
    #1;
    if (pop) check("pop_data", dout, q[0]);
    @(posedge sd_clk);
    #1;
    if (!rs || f) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (w && (n == 8) && !pop) m_ovf = 1;
      if (r && (n == 0)) m_udf = 1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
    compare_state();
  endtask

  function automatic vec_t mk(bit w, bit rs, logic [31:0] d, int c,
                              bit e, bit fu, bit af, bit ae, bit ov);
    vec_t v;
    v.w = w; v.r = 0; v.f = 0; v.rs = rs; v.d = d;
    v.e_count = c; v.e_empty = e; v.e_full = fu;
    v.e_af = af; v.e_ae = ae; v.e_ovf = ov;
    return v;
  endfunction

  initial begin
    vec_t tbl[10];
    tbl[0] = mk(0, 0, 32'h0,        0, 1, 0, 0, 1, 0);
    tbl[1] = mk(1, 1, 32'hA0000001, 1, 0, 0, 0, 1, 0);
    tbl[2] = mk(1, 1, 32'hA0000002, 2, 0, 0, 0, 0, 0);
    tbl[3] = mk(1, 1, 32'hA0000003, 3, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 1, 32'hA0000004, 4, 0, 0, 0, 0, 0);
    tbl[5] = mk(1, 1, 32'hA0000005, 5, 0, 0, 0, 0, 0);
    tbl[6] = mk(1, 1, 32'hA0000006, 6, 0, 0, 1, 0, 0);
    tbl[7] = mk(1, 1, 32'hA0000007, 7, 0, 0, 1, 0, 0);
    tbl[8] = mk(1, 1, 32'hA0000008, 8, 0, 1, 1, 0, 0);
    tbl[9] = mk(1, 1, 32'hDEADBEEF, 8, 0, 1, 1, 0, 1);

    rst_L = 0; flush = 0; wr_enb = 0; rd_enb = 0; din = '0;

    // Reset, fill to full, then one dropped write
    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].rs, tbl[i].d);
      check("tbl_count", 32'(count), 32'(tbl[i].e_count));
      check("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
      check("tbl_full", 32'(full), 32'(tbl[i].e_full));
      check("tbl_af", 32'(almost_full), 32'(tbl[i].e_af));
      check("tbl_ae", 32'(almost_empty), 32'(tbl[i].e_ae));
      check("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Drain in order; dropped word must not appear
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1, '0);
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_dout", dout, 32'h0);

    // Simultaneous write and read on empty
    cycle(0, 0, 1, 1, '0);
    cycle(1, 1, 0, 1, 32'h12345678);
    check("wr_rd_empty_udf", 32'(underflow), 32'h1);
    check("wr_rd_empty_cnt", 32'(count), 32'h1);
    check("wr_rd_empty_dout", dout, 32'h12345678);

    // Full with continuous push+pop across the pointer wrap
    cycle(0, 0, 1, 1, '0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 32'hB0000000 + 32'(i));
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 1, 32'hC0000000 + 32'(i));
    check("stream_cnt", 32'(count), 32'h8);
    check("stream_ovf", 32'(overflow), 32'h0);
    check("stream_udf", 32'(underflow), 32'h0);

    // Flush overrides a concurrent write
    cycle(0, 0, 1, 1, '0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 32'hD0000000 + 32'(i));
    cycle(0, 1, 0, 1, '0);
    cycle(1, 0, 0, 1, 32'hD0000005);
    cycle(1, 0, 1, 1, 32'hEEEEEEEE);
    check("flush_cnt", 32'(count), 32'h0);
    check("flush_empty", 32'(empty), 32'h1);
    check("flush_udf", 32'(underflow), 32'h0);
    cycle(0, 0, 0, 1, '0);
    check("flush_nostore", 32'(count), 32'h0);

    // Reset mid-operation, then a single push shows one cycle later
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 32'hF0000000 + 32'(i));
    cycle(1, 1, 1, 0, 32'h99999999);
    check("rst_cnt", 32'(count), 32'h0);
    check("rst_dout", dout, 32'h0);
    wr_enb = 1; din = 32'h55; rd_enb = 0; flush = 0; rst_L = 1;
    #1;
    check("no_write_through", dout, 32'h0);
    cycle(1, 0, 0, 1, 32'h55);
    check("post_rst_dout", dout, 32'h55);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) != 0),
            $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default `FIFO_WIDTH (32), word width.
REQ-002 SHALL have parameter ADDR_W, default 3, log2 of depth; DEPTH = 2**ADDR_W (8).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold.
REQ-004 SHALL have parameter AE_LVL, default 1, almost_empty threshold.
REQ-005 sd_clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_L  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  synchronous clear of contents and pointers.
REQ-008 wr_enb  in  1  push din this cycle.
REQ-009 din  in  DATA_W  write data.
REQ-010 rd_enb  in  1  pop head word this cycle; driven by DAT transmit stage (tx_buf_rd_enb).
REQ-011 dout  out  DATA_W  head word, show-ahead; feeds tx_buf_dout_in.
REQ-012 empty  out  1  no valid word; DAT transmit stage treats !empty as "data available".
REQ-013 full  out  1  DEPTH words stored.
REQ-014 almost_full  out  1  count >= AF_LVL.
REQ-015 almost_empty  out  1  count <= AE_LVL.
REQ-016 count  out  ADDR_W+1  words stored, 0..DEPTH.
REQ-017 overflow  out  1  sticky: write attempted while full and no pop.
REQ-018 underflow  out  1  sticky: read attempted while empty.

Function
REQ-019 Show-ahead: dout SHALL equal mem[rd_ptr] combinationally whenever empty=0, and SHALL be all-zero when empty=1.
REQ-020 Pop SHALL occur on an edge where rd_enb=1 and empty=0; rd_ptr increments; the next word appears on dout in the following cycle.
REQ-021 Push SHALL occur on an edge where wr_enb=1 and (full=0 or a pop occurs that cycle); mem[wr_ptr] <= din, wr_ptr increments.
REQ-022 A pushed word SHALL NOT appear on dout in the same cycle (no write-through); write-to-dout latency is 1 cycle when empty.
REQ-023 Pointers SHALL be ADDR_W+1 bits and wrap modulo 2*DEPTH; full when addresses match and wrap bits differ, empty when pointers are equal.
REQ-024 count SHALL be registered: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-025 empty, full, almost_full and almost_empty SHALL be decoded from registered count/pointers, with no combinational path from wr_enb or rd_enb.
REQ-026 Simultaneous push+pop when full: both accepted, count stays DEPTH, overflow not set.
REQ-027 Simultaneous wr_enb+rd_enb when empty: push accepted, pop ignored, underflow set, count becomes 1.
REQ-028 Write while full without pop: data dropped, pointers unchanged, overflow set.
REQ-029 Read while empty: no pointer change, underflow set.
REQ-030 overflow and underflow SHALL clear only on reset or flush.
REQ-031 flush=1 SHALL zero pointers, count and sticky flags next edge; it overrides wr_enb and rd_enb in the same cycle; mem contents need not be cleared.

Reset
REQ-032 On an edge with rst_L=0: rd_ptr=0, wr_ptr=0, count=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0, dout=0.
REQ-033 Reset mid-operation SHALL discard all stored words; mem contents are don't-care after reset.
REQ-034 Reset SHALL take priority over flush, wr_enb and rd_enb.

Structure
REQ-035 `FIFO_WIDTH, default TX_FIFO_ADDR_W and threshold constants SHALL live in the shared defines file used by the DAT blocks.
REQ-036 The storage array SHALL be a sub-module fifo_mem: one synchronous write port, one asynchronous read port, no reset.
REQ-037 Pointer, count and flag logic SHALL reside in tx_fifo.

Verification
REQ-038 Reset, then push 0xA0000001..0xA0000008 -> full=1, count=8, almost_full set at count=6; one further push -> overflow=1, count=8.
REQ-039 From full, pop 8 times -> dout sequence 0xA0000001..0xA0000008 in order, empty=1 after the 8th pop, dout=0.
REQ-040 From empty, assert wr_enb+rd_enb with din=0x12345678 -> underflow=1, count=1, dout=0x12345678 next cycle.
REQ-041 From full, 20 cycles of continuous push+pop -> count stays 8, data stays in order across pointer wrap, no sticky flags set.
REQ-042 At count=5, assert flush together with wr_enb -> count=0, empty=1, flags cleared, no word stored.
REQ-043 At count=5, drive rst_L=0 for one edge -> REQ-032 values; subsequent push of 0x55 -> dout=0x55 one cycle later.
